sys_tx_scheduler: RTL and testbench

Output-side scheduler for the system controller's UART transmit path. It buffers two requester streams in independent FIFOs: 8-bit register-file read results and 16-bit ALU results. It arbitrates between them round-robin and serialises each grant into byte transfers to the UART TX using a valid/busy handshake. Each ALU result is sent as two bytes, low byte then high byte, with no interleaving.

---
 rtl/sys_tx_scheduler_if.sv | 29 ++
 rtl/sys_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_sys_tx_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_tx_scheduler_if.sv
// Signal bundle between the requesters/UART and the TX scheduler.
// The master side pushes results and reports UART busy. The slave side is the scheduler.
interface sys_tx_scheduler_if #(
  parameter int WIDTH = 8
);
  logic               rf_send_in;
  logic [WIDTH-1:0]   rf_send_data_in;
  logic               alu_send_in;
  logic [2*WIDTH-1:0] alu_send_data_in;
  logic               uart_tx_busy_in;
  logic [WIDTH-1:0]   uart_tx_data_out;
  logic               uart_tx_data_valid_out;
  logic               rf_queue_full_out;
  logic               alu_queue_full_out;
  logic               overflow_out;
  logic               tx_idle_out;

  modport master (
    output rf_send_in, rf_send_data_in, alu_send_in, alu_send_data_in, uart_tx_busy_in,
    input  uart_tx_data_out, uart_tx_data_valid_out, rf_queue_full_out,
           alu_queue_full_out, overflow_out, tx_idle_out
  );

  modport slave (
    input  rf_send_in, rf_send_data_in, alu_send_in, alu_send_data_in, uart_tx_busy_in,
    output uart_tx_data_out, uart_tx_data_valid_out, rf_queue_full_out,
           alu_queue_full_out, overflow_out, tx_idle_out
  );
endinterface

// File: rtl/sys_tx_scheduler.sv
// UART TX scheduler: two result FIFOs (8-bit RF, 16-bit ALU) drained round-robin.
// Each grant is sent as bytes over a valid/busy handshake. An ALU result goes out low byte first, then high byte.
module sys_tx_scheduler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  sys_tx_scheduler_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   rf_mem  [DEPTH];
  logic [2*WIDTH-1:0] alu_mem [DEPTH];
  logic [PW-1:0]      rf_wr_ptr, rf_rd_ptr, alu_wr_ptr, alu_rd_ptr;
  logic [CW-1:0]      rf_count, alu_count, rf_count_next, alu_count_next;
  logic               rf_push, alu_push, rf_drop, alu_drop, rf_pop, alu_pop;
  logic               rf_ne, alu_ne;
  logic [WIDTH-1:0]   rf_head;
  logic [2*WIDTH-1:0] alu_head;

  logic [WIDTH-1:0]   data_q, data_next, hi_q, hi_next;
  logic               valid_q, valid_next, hi_pend_q, hi_pend_next;
  logic               last_alu_q, last_alu_next;
  logic               rf_full_q, alu_full_q, overflow_q, idle_q;

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign rf_push        = bus.rf_send_in  && ((rf_count  != FULL_CNT) || rf_pop);
  assign alu_push       = bus.alu_send_in && ((alu_count != FULL_CNT) || alu_pop);
  assign rf_drop        = bus.rf_send_in  && !rf_push;
  assign alu_drop       = bus.alu_send_in && !alu_push;
  assign rf_count_next  = rf_count  + CW'(rf_push)  - CW'(rf_pop);
  assign alu_count_next = alu_count + CW'(alu_push) - CW'(alu_pop);
  assign rf_ne          = (rf_count  != '0);
  assign alu_ne         = (alu_count != '0);
  assign rf_head        = rf_mem[rf_rd_ptr];
  assign alu_head       = alu_mem[alu_rd_ptr];

  // NOTE: storage arrays are not reset; clearing pointers and counts already empties the queues.
  always_ff @(posedge clk) begin
    if (rf_push)  rf_mem[rf_wr_ptr]   <= bus.rf_send_data_in;
    if (alu_push) alu_mem[alu_wr_ptr] <= bus.alu_send_data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wr_ptr  <= '0;
      rf_rd_ptr  <= '0;
      rf_count   <= '0;
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_count  <= '0;
    end else begin
      if (rf_push)  rf_wr_ptr  <= rf_wr_ptr  + PW'(1);
      if (rf_pop)   rf_rd_ptr  <= rf_rd_ptr  + PW'(1);
      if (alu_push) alu_wr_ptr <= alu_wr_ptr + PW'(1);
      if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PW'(1);
      rf_count  <= rf_count_next;
      alu_count <= alu_count_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    data_next     = data_q;
    valid_next    = valid_q;
    hi_next       = hi_q;
    hi_pend_next  = hi_pend_q;
    last_alu_next = last_alu_q;
    rf_pop        = 1'b0;
    alu_pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!bus.uart_tx_busy_in && (rf_ne || alu_ne)) begin
          if (alu_ne && (!rf_ne || !last_alu_q)) begin
            alu_pop       = 1'b1;
            data_next     = alu_head[WIDTH-1:0];
            hi_next       = alu_head[2*WIDTH-1:WIDTH];
            hi_pend_next  = 1'b1;
            last_alu_next = 1'b1;
          end else begin
            rf_pop        = 1'b1;
            data_next     = rf_head;
            hi_pend_next  = 1'b0;
            last_alu_next = 1'b0;
          end
          valid_next = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.uart_tx_busy_in) begin
          valid_next = 1'b0;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy_in) begin
          if (hi_pend_q) begin
            data_next    = hi_q;
            valid_next   = 1'b1;
            hi_pend_next = 1'b0;
            state_next   = WAIT_ACK;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      hi_q       <= '0;
      hi_pend_q  <= 1'b0;
      last_alu_q <= 1'b1;
      rf_full_q  <= 1'b0;
      alu_full_q <= 1'b0;
      overflow_q <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state      <= state_next;
      data_q     <= data_next;
      valid_q    <= valid_next;
      hi_q       <= hi_next;
      hi_pend_q  <= hi_pend_next;
      last_alu_q <= last_alu_next;
      rf_full_q  <= (rf_count_next  == FULL_CNT);
      alu_full_q <= (alu_count_next == FULL_CNT);
      overflow_q <= rf_drop || alu_drop;
      idle_q     <= (state_next == IDLE) && (rf_count_next == '0) && (alu_count_next == '0);
    end
  end

  assign bus.uart_tx_data_out       = data_q;
  assign bus.uart_tx_data_valid_out = valid_q;
  assign bus.rf_queue_full_out      = rf_full_q;
  assign bus.alu_queue_full_out     = alu_full_q;
  assign bus.overflow_out           = overflow_q;
  assign bus.tx_idle_out            = idle_q;
endmodule

// File: tb/tb_sys_tx_scheduler.sv
// Bench for sys_tx_scheduler: a cycle-by-cycle vector table, then hand sequences driven by a small UART busy model.
module tb_sys_tx_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy_man = 1'b0;
  logic busy_model = 1'b0;
  logic model_on = 1'b0;
  logic prev_valid = 1'b0;
  int   hold = 0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] captured [$];

  sys_tx_scheduler_if #(.WIDTH(8)) bus ();
  sys_tx_scheduler #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.uart_tx_busy_in = model_on ? busy_model : busy_man;

  always #5 clk = ~clk;

  // UART model: busy rises one cycle after valid and stays high for 10 cycles. Every valid rise is logged.
  always @(posedge clk) begin
    #1;
    if (bus.uart_tx_data_valid_out && !prev_valid) captured.push_back(bus.uart_tx_data_out);
    prev_valid = bus.uart_tx_data_valid_out;
    if (!model_on) begin
      hold = 0;
      busy_model = 1'b0;
    end else if (hold > 0) begin
      hold = hold - 1;
      if (hold == 0) busy_model = 1'b0;
    end else if (bus.uart_tx_data_valid_out && !busy_model) begin
      busy_model = 1'b1;
      hold = 10;
    end
  end

  typedef struct {
    logic        rf_send;
    logic [7:0]  rf_data;
    logic        alu_send;
    logic [15:0] alu_data;
    logic        busy;
    logic [7:0]  exp_data;
    logic        exp_valid;
    logic        exp_rf_full;
    logic        exp_alu_full;
    logic        exp_ovf;
    logic        exp_idle;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    busy_man = 1'b0;
    bus.rf_send_in = 1'b0;
    bus.alu_send_in = 1'b0;
    #2 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_bytes(input string name, input int base, input int n);
    int cyc = 0;
    while ((captured.size() < base + n || !bus.tx_idle_out) && cyc < 400) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check({name, "_timeout"}, 16'(cyc < 400), 16'd1);
    repeat (20) @(posedge clk);
    #2;
    check({name, "_count"}, 16'(captured.size() - base), 16'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] exp_rr [4];
    //           rf  rfd    alu aluD      bsy  data  v  rff aff ovf idle
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h77, 1'b0, 16'h0000, 1'b0, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    bus.rf_send_in = 1'b0;
    bus.rf_send_data_in = '0;
    bus.alu_send_in = 1'b0;
    bus.alu_send_data_in = '0;
    tick();
    check("in_reset_valid", 16'(bus.uart_tx_data_valid_out), 16'd0);
    check("in_reset_idle", 16'(bus.tx_idle_out), 16'd1);
    tick();
    reset = 1'b0;

    // Single RF byte, then an ALU pair with an RF byte arriving between its halves.
    for (int i = 0; i < 16; i++) begin
      bus.rf_send_in       = vecs[i].rf_send;
      bus.rf_send_data_in  = vecs[i].rf_data;
      bus.alu_send_in      = vecs[i].alu_send;
      bus.alu_send_data_in = vecs[i].alu_data;
      busy_man             = vecs[i].busy;
      tick();
      check($sformatf("v%0d_data", i), 16'(bus.uart_tx_data_out), 16'(vecs[i].exp_data));
      check($sformatf("v%0d_valid", i), 16'(bus.uart_tx_data_valid_out), 16'(vecs[i].exp_valid));
      check($sformatf("v%0d_rf_full", i), 16'(bus.rf_queue_full_out), 16'(vecs[i].exp_rf_full));
      check($sformatf("v%0d_alu_full", i), 16'(bus.alu_queue_full_out), 16'(vecs[i].exp_alu_full));
      check($sformatf("v%0d_ovf", i), 16'(bus.overflow_out), 16'(vecs[i].exp_ovf));
      check($sformatf("v%0d_idle", i), 16'(bus.tx_idle_out), 16'(vecs[i].exp_idle));
    end
    bus.rf_send_in = 1'b0;
    bus.alu_send_in = 1'b0;

    // Round robin right after reset: RF wins the first tie, and the ALU pair stays together.
    do_reset();
    model_on = 1'b1;
    base = captured.size();
    bus.rf_send_in = 1'b1;
    bus.rf_send_data_in = 8'h01;
    bus.alu_send_in = 1'b1;
    bus.alu_send_data_in = 16'hBEEF;
    tick();
    bus.alu_send_in = 1'b0;
    bus.rf_send_data_in = 8'h02;
    tick();
    bus.rf_send_in = 1'b0;
    wait_bytes("rr", base, 4);
    exp_rr[0] = 8'h01;
    exp_rr[1] = 8'hEF;
    exp_rr[2] = 8'hBE;
    exp_rr[3] = 8'h02;
    for (int k = 0; k < 4; k++)
      if (captured.size() > base + k) check($sformatf("rr_byte%0d", k), 16'(captured[base+k]), 16'(exp_rr[k]));

    // Five RF pushes with busy stuck high: the fifth is dropped with a single overflow pulse.
    do_reset();
    busy_man = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.rf_send_in = 1'b1;
      bus.rf_send_data_in = 8'(8'h10 + k);
      tick();
      if (k == 2) check("ovf_rf_full_at3", 16'(bus.rf_queue_full_out), 16'd0);
      if (k == 3) begin
        check("ovf_rf_full_at4", 16'(bus.rf_queue_full_out), 16'd1);
        check("ovf_none_at4", 16'(bus.overflow_out), 16'd0);
      end
      if (k == 4) begin
        check("ovf_pulse", 16'(bus.overflow_out), 16'd1);
        check("ovf_rf_full_at5", 16'(bus.rf_queue_full_out), 16'd1);
      end
    end
    bus.rf_send_in = 1'b0;
    tick();
    check("ovf_pulse_end", 16'(bus.overflow_out), 16'd0);
    check("ovf_no_send_while_busy", 16'(bus.uart_tx_data_valid_out), 16'd0);
    base = captured.size();
    model_on = 1'b1;
    wait_bytes("ovf", base, 4);
    for (int k = 0; k < 4; k++)
      if (captured.size() > base + k) check($sformatf("ovf_byte%0d", k), 16'(captured[base+k]), 16'(8'h10 + k));

    // Full RF queue popped and pushed on the same edge: push accepted, count stays full.
    do_reset();
    busy_man = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.rf_send_in = 1'b1;
      bus.rf_send_data_in = 8'(8'h20 + k);
      tick();
    end
    check("pp_full_before", 16'(bus.rf_queue_full_out), 16'd1);
    base = captured.size();
    busy_man = 1'b0;
    bus.rf_send_data_in = 8'h24;
    tick();
    bus.rf_send_in = 1'b0;
    check("pp_no_ovf", 16'(bus.overflow_out), 16'd0);
    check("pp_full_kept", 16'(bus.rf_queue_full_out), 16'd1);
    check("pp_valid", 16'(bus.uart_tx_data_valid_out), 16'd1);
    check("pp_head", 16'(bus.uart_tx_data_out), 16'h20);
    model_on = 1'b1;
    wait_bytes("pp", base, 5);
    for (int k = 0; k < 5; k++)
      if (captured.size() > base + k) check($sformatf("pp_byte%0d", k), 16'(captured[base+k]), 16'(8'h20 + k));

    // Reset during WAIT_ACK of an ALU low byte abandons the pair.
    do_reset();
    bus.alu_send_in = 1'b1;
    bus.alu_send_data_in = 16'hC33C;
    tick();
    bus.alu_send_in = 1'b0;
    check("rst_latency_valid_low", 16'(bus.uart_tx_data_valid_out), 16'd0);
    tick();
    check("rst_lo_valid", 16'(bus.uart_tx_data_valid_out), 16'd1);
    check("rst_lo_data", 16'(bus.uart_tx_data_out), 16'h3C);
    tick();
    check("rst_lo_held", 16'(bus.uart_tx_data_valid_out), 16'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_valid_drop", 16'(bus.uart_tx_data_valid_out), 16'd0);
    check("rst_data_zero", 16'(bus.uart_tx_data_out), 16'h00);
    check("rst_idle", 16'(bus.tx_idle_out), 16'd1);
    tick();
    reset = 1'b0;
    base = captured.size();
    model_on = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("rst_no_hi_byte", 16'(captured.size() - base), 16'd0);
    check("rst_idle_after", 16'(bus.tx_idle_out), 16'd1);
    check("rst_valid_after", 16'(bus.uart_tx_data_valid_out), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
